// File: rtl/req_queue.sv
// -----------------------------------------------------------------------------
// req_queue
//
// Host-side request queue sitting directly upstream of the control FSM.
//
// The host CPU delivers each REQW-bit instruction as a stream of NBYTES bytes,
// least-significant byte first. The bytes are gathered in an assembly register.
// When the last byte arrives, the complete word goes into a DEPTH-entry
// first-word-fall-through FIFO. The head entry is always presented on
// req_valid/req_data, and the FSM dequeues it with ready_req_in.
//
// Parameters
//   ADDRW   address width; instruction width REQW = 3*ADDRW+2 (ADDRW >= 3)
//   DEPTH   FIFO entries, power of two, >= 2
//   REQW, NBYTES = ceil(REQW/8), CNTW = clog2(DEPTH+1) are derived.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   flush          (only with REQ_QUEUE_FLUSH_EN) synchronous clear of the
//                  queue and of any partially assembled word
//   host_valid     host byte valid
//   host_data[7:0] host byte
//   host_ready     byte is accepted this cycle when host_valid is also high
//   req_valid      head entry available
//   req_data       head entry (all zeros while empty)
//   ready_req_in   FSM ready; pops the head when req_valid is high
//   full           FIFO holds DEPTH entries
//   count          number of stored entries
//
// Optional feature
//   REQ_QUEUE_FLUSH_EN adds the flush input. Without it, the queue contents
//   are cleared only by rst_n.
// -----------------------------------------------------------------------------
module req_queue #(
  parameter  int ADDRW  = 24,
  parameter  int DEPTH  = 4,
  localparam int REQW   = 3 * ADDRW + 2,
  localparam int NBYTES = (REQW + 7) / 8,
  localparam int CNTW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef REQ_QUEUE_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            host_valid,
  input  logic [7:0]      host_data,
  output logic            host_ready,
  output logic            req_valid,
  output logic [REQW-1:0] req_data,
  input  logic            ready_req_in,
  output logic            full,
  output logic [CNTW-1:0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int BCW  = $clog2(NBYTES);
  localparam int ASMW = 8 * (NBYTES - 1);
  localparam logic [BCW-1:0]  LAST_IDX  = BCW'(NBYTES - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ASMW-1:0] asm_q, asm_d;

  logic [REQW-1:0] mem [DEPTH];

  logic            flush_w;
  logic            in_last;
  logic            accept;
  logic            push;
  logic            pop;
  logic [REQW-1:0] push_word;

`ifdef REQ_QUEUE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    in_last = (byte_cnt_q == LAST_IDX);
    // The final byte may only enter while there is room. The registered full
    // is used, so a pop in the same cycle does not open a bypass path.
    // A flush cycle reports ready but discards the offered byte.
    host_ready = flush_w | ~in_last | ~full_q;
    accept     = host_valid & host_ready & ~flush_w;
    push       = accept & in_last;
    pop        = (count_q != '0) & ready_req_in & ~flush_w;
    // The final byte sits above the assembled bytes. Its bits above REQW-1
    // are dropped.
    push_word  = REQW'({host_data, asm_q});
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;

    for (int k = 0; k < NBYTES - 1; k++) begin
      if (accept && !in_last && byte_cnt_q == BCW'(k)) begin
        asm_d[8*k +: 8] = host_data;
      end
    end

    if (accept) begin
      byte_cnt_d = in_last ? '0 : byte_cnt_q + BCW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    if (flush_w) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      byte_cnt_d = '0;
    end

    full_d = (count_d == DEPTH_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  // Storage is not reset. An empty queue masks req_data, so stale entries
  // are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  assign req_valid = (count_q != '0);
  assign req_data  = req_valid ? mem[rd_ptr_q] : '0;
  assign full      = full_q;
  assign count     = count_q;

endmodule

// File: tb/tb_req_queue.sv
// Directed bench for req_queue with its default parameters (REQW=74, DEPTH=4).
// Instruction words are built from a first byte f: byte k = f + k.
module tb_req_queue;

  localparam int REQW = 74;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            host_valid;
  logic [7:0]      host_data;
  logic            host_ready;
  logic            req_valid;
  logic [REQW-1:0] req_data;
  logic            ready_req_in;
  logic            full;
  logic [CNTW-1:0] count;
`ifdef REQ_QUEUE_FLUSH_EN
  logic            flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  req_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef REQ_QUEUE_FLUSH_EN
    .flush        (flush),
`endif
    .host_valid   (host_valid),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .ready_req_in (ready_req_in),
    .full         (full),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Expected 74-bit word: bytes f, f+1, ..., f+9 LSB-first; the top 6 bits of the last byte are dropped.
  function automatic logic [REQW-1:0] exp_word(input logic [7:0] f);
    logic [79:0] w;
    for (int k = 0; k < 10; k++) w[8*k +: 8] = f + 8'(k);
    return w[REQW-1:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    host_valid = 1'b1;
    host_data  = b;
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [7:0] f);
    for (int k = 0; k < 10; k++) send_byte(f + 8'(k));
  endtask

  task automatic pop_one();
    ready_req_in = 1'b1;
    @(posedge clk);
    #1;
    ready_req_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    host_valid   = 1'b0;
    host_data    = 8'h00;
    ready_req_in = 1'b0;
`ifdef REQ_QUEUE_FLUSH_EN
    flush        = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 80'(req_valid), 80'd0);
    chk("rst_req_data", 80'(req_data), 80'd0);
    chk("rst_full", 80'(full), 80'd0);
    chk("rst_host_ready", 80'(host_ready), 80'd1);
    chk("rst_count", 80'(count), 80'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single instruction 0x01..0x0A: final byte 0x0A keeps only 2'b10.
    for (int k = 0; k < 9; k++) send_byte(8'(k + 1));
    chk("single_no_valid_before_last", 80'(req_valid), 80'd0);
    send_byte(8'h0A);
    chk("single_req_valid", 80'(req_valid), 80'd1);
    chk("single_req_data", 80'(req_data), 80'h2090807060504030201);
    chk("single_count", 80'(count), 80'd1);
    @(posedge clk);
    #1;
    chk("single_hold_data", 80'(req_data), 80'h2090807060504030201);

    // Pop timing.
    pop_one();
    chk("pop_req_valid", 80'(req_valid), 80'd0);
    chk("pop_count", 80'(count), 80'd0);
    chk("pop_req_data", 80'(req_data), 80'd0);
    pop_one();
    chk("pop_empty_count", 80'(count), 80'd0);

    // Fill to full with instructions 0x40, 0x50, 0x60, 0x70.
    for (int i = 0; i < 4; i++) send_instr(8'h40 + 8'(16 * i));
    chk("fill_full", 80'(full), 80'd1);
    chk("fill_count", 80'(count), 80'd4);
    chk("fill_head", 80'(req_data), 80'(exp_word(8'h40)));
    // The fifth instruction (0x80) is accepted for bytes 0..8.
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("fill_hr_b%0d", k), 80'(host_ready), 80'd1);
      send_byte(8'h80 + 8'(k));
    end
    chk("fill_count_partial", 80'(count), 80'd4);
    host_valid = 1'b1;
    host_data  = 8'h89;
    chk("fill_hr_b9", 80'(host_ready), 80'd0);
    @(posedge clk);
    #1;
    chk("fill_hr_b9_held", 80'(host_ready), 80'd0);
    chk("fill_count_held", 80'(count), 80'd4);
    ready_req_in = 1'b1;
    @(posedge clk);
    #1;
    ready_req_in = 1'b0;
    chk("fill_hr_after_pop", 80'(host_ready), 80'd1);
    chk("fill_count_after_pop", 80'(count), 80'd3);
    chk("fill_full_after_pop", 80'(full), 80'd0);
    chk("fill_head_after_pop", 80'(req_data), 80'(exp_word(8'h50)));
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    chk("fill_count_refill", 80'(count), 80'd4);
    chk("fill_full_refill", 80'(full), 80'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_drain_%0d", i), 80'(req_data), 80'(exp_word(8'h50 + 8'(16 * i))));
      pop_one();
    end
    chk("fill_drain_empty", 80'(req_valid), 80'd0);

    // Simultaneous push and pop.
    send_instr(8'hB0);
    send_instr(8'hC0);
    for (int k = 0; k < 9; k++) send_byte(8'hD0 + 8'(k));
    ready_req_in = 1'b1;
    send_byte(8'hD9);
    ready_req_in = 1'b0;
    chk("pushpop_count", 80'(count), 80'd2);
    chk("pushpop_head", 80'(req_data), 80'(exp_word(8'hC0)));
    pop_one();
    chk("pushpop_next", 80'(req_data), 80'(exp_word(8'hD0)));
    pop_one();
    chk("pushpop_empty", 80'(count), 80'd0);

    // Wrap: six instructions 0x10..0x15 through the queue, two in flight.
    send_instr(8'h10);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) send_instr(8'h11 + 8'(i));
      chk($sformatf("wrap_%0d", i), 80'(req_data), 80'(exp_word(8'h10 + 8'(i))));
      pop_one();
    end
    chk("wrap_empty", 80'(count), 80'd0);

    // Reset with one entry stored and a partial word at byte 5.
    send_instr(8'hE0);
    for (int k = 0; k < 5; k++) send_byte(8'hF0 + 8'(k));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 80'(req_valid), 80'd0);
    chk("midrst_req_data", 80'(req_data), 80'd0);
    chk("midrst_count", 80'(count), 80'd0);
    chk("midrst_full", 80'(full), 80'd0);
    chk("midrst_host_ready", 80'(host_ready), 80'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_instr(8'h21);
    chk("postrst_count", 80'(count), 80'd1);
    chk("postrst_data", 80'(req_data), 80'(exp_word(8'h21)));
    pop_one();

`ifdef REQ_QUEUE_FLUSH_EN
    for (int i = 0; i < 3; i++) send_instr(8'h30 + 8'(i));
    for (int k = 0; k < 4; k++) send_byte(8'h90 + 8'(k));
    flush        = 1'b1;
    ready_req_in = 1'b1;
    host_valid   = 1'b1;
    host_data    = 8'h55;
    chk("flush_hr", 80'(host_ready), 80'd1);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    ready_req_in = 1'b0;
    host_valid   = 1'b0;
    chk("flush_count", 80'(count), 80'd0);
    chk("flush_req_valid", 80'(req_valid), 80'd0);
    chk("flush_full", 80'(full), 80'd0);
    send_instr(8'hA5);
    chk("flush_new_count", 80'(count), 80'd1);
    chk("flush_new_data", 80'(req_data), 80'(exp_word(8'hA5)));
    pop_one();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
